tri_z_interp: RTL and testbench

//  Per-pixel depth interpolator for the raster stage. A triangle (three 3D vertices) is loaded once.

---
 rtl/tri_z_interp_pkg.sv | 70 +++++++
 rtl/tri_z_interp_div.sv | 60 ++++++
 rtl/tri_z_interp.sv | 140 ++++++++++++++
 tb/tb_tri_z_interp.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_z_interp_pkg.sv
// Shared types and arithmetic helpers for the triangle depth interpolator.
// Widths here are the reference widths the interpolator datapath is built on.
package tri_z_interp_pkg;

  localparam int COORD_W_DEF = 16;
  localparam int Z_W_DEF     = 16;
  localparam int EDGE_W_DEF  = 2*COORD_W_DEF + 3;
  localparam int NUM_W_DEF   = Z_W_DEF + EDGE_W_DEF + 2;

  typedef logic signed [COORD_W_DEF-1:0] coord_t;
  typedef logic signed [Z_W_DEF-1:0]     z_t;
  typedef logic signed [EDGE_W_DEF-1:0]  edge_t;
  typedef logic signed [NUM_W_DEF-1:0]   num_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
    z_t     z;
  } vertex_t;

  typedef struct packed {
    vertex_t p;
    vertex_t q;
    vertex_t r;
  } triangle_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_LOADED, S_EDGE, S_MUL, S_DIV, S_OUT
  } state_t;

  localparam z_t Z_MAX = {1'b0, {(Z_W_DEF-1){1'b1}}};
  localparam z_t Z_MIN = {1'b1, {(Z_W_DEF-1){1'b0}}};

  // Exact signed edge function; EDGE_W leaves headroom for full-range coordinates.
  function automatic edge_t edge_fn(input vertex_t a, input vertex_t b, input vertex_t c);
    edge_t bax, bay, cax, cay;
    bax = edge_t'($signed(b.x)) - edge_t'($signed(a.x));
    bay = edge_t'($signed(b.y)) - edge_t'($signed(a.y));
    cax = edge_t'($signed(c.x)) - edge_t'($signed(a.x));
    cay = edge_t'($signed(c.y)) - edge_t'($signed(a.y));
    return bax * cay - bay * cax;
  endfunction

  function automatic z_t sat_to_zw(input num_t v);
    if (v > num_t'(Z_MAX)) return Z_MAX;
    if (v < num_t'(Z_MIN)) return Z_MIN;
    return v[Z_W_DEF-1:0];
  endfunction

  // Legacy bounding-box helpers kept for existing callers.
  function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic edge_t triangle_area(input triangle_t t);
    edge_t w, h;
    w = edge_t'(max3(t.p.x, t.q.x, t.r.x)) - edge_t'(min3(t.p.x, t.q.x, t.r.x));
    h = edge_t'(max3(t.p.y, t.q.y, t.r.y)) - edge_t'(min3(t.p.y, t.q.y, t.r.y));
    return w * h;
  endfunction

endpackage

// File: rtl/tri_z_interp_div.sv
// Sequential restoring divider: signed dividend / unsigned divisor, quotient
// truncated toward zero, one quotient bit per cycle, N_W cycles after start.
module seq_sdiv #(
  parameter int N_W = 53,
  parameter int D_W = 35
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic signed [N_W-1:0] dividend,
  input  logic        [D_W-1:0] divisor,
  output logic                  done,
  output logic signed [N_W-1:0] quotient
);

  localparam int CNT_W = $clog2(N_W + 1);

  logic [N_W-1:0]   q_r, q_nxt;
  logic [D_W-1:0]   rem_r, rem_nxt, dsr_r;
  logic [D_W:0]     rem_sh;
  logic             fits, neg_r;
  logic [CNT_W-1:0] cnt_r;

  // The magnitude of the dividend is shifted out of q_r MSB-first while
  // quotient bits shift in at the LSB.
  always_comb begin
    rem_sh  = {rem_r, q_r[N_W-1]};
    fits    = (rem_sh >= {1'b0, dsr_r});
    rem_nxt = fits ? D_W'(rem_sh - {1'b0, dsr_r}) : rem_sh[D_W-1:0];
    q_nxt   = {q_r[N_W-2:0], fits};
  end

  // done flags the final iteration so the caller can register the result on
  // the same edge; quotient already reflects that iteration.
  assign done     = (cnt_r == CNT_W'(1));
  assign quotient = neg_r ? -$signed(q_nxt) : $signed(q_nxt);

  // NOTE: non-blocking assignments in every clocked block, so all registers
  // update from pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)              cnt_r <= '0;
    else if (start)          cnt_r <= CNT_W'(N_W);
    else if (cnt_r != '0)    cnt_r <= cnt_r - 1'b1;
  end

  // NOTE: pure datapath registers carry no reset; they are always loaded by
  // start before cnt_r lets anything consume them.
  always_ff @(posedge clk) begin
    if (start) begin
      q_r   <= dividend[N_W-1] ? -dividend : dividend;
      rem_r <= '0;
      dsr_r <= divisor;
      neg_r <= dividend[N_W-1];
    end else if (cnt_r != '0) begin
      q_r   <= q_nxt;
      rem_r <= rem_nxt;
    end
  end

endmodule

// File: rtl/tri_z_interp.sv
// Per-pixel barycentric depth interpolator: load a triangle once, then stream
// pixels through edge functions, a z MAC and a sequential divide.
module tri_z_interp
  import tri_z_interp_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int Z_W     = Z_W_DEF
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          tri_valid,
  output logic                          tri_ready,
  input  logic [3*(2*COORD_W+Z_W)-1:0]  tri_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  input  logic signed [COORD_W-1:0]     pix_x,
  input  logic signed [COORD_W-1:0]     pix_y,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [Z_W-1:0]         out_z,
  output logic                          out_inside,
  output logic                          out_degen,
  output logic                          busy
);

  localparam int EDGE_W = 2*COORD_W + 3;
  localparam int NUM_W  = Z_W + EDGE_W + 2;

  // Datapath types come from the package, so the widths must agree with it.
  if (COORD_W != COORD_W_DEF || Z_W != Z_W_DEF) begin : g_width_check
    $error("tri_z_interp: COORD_W/Z_W must match tri_z_interp_pkg widths");
  end

  state_t              state, state_nxt;
  triangle_t           tri_r;
  coord_t              pix_x_r, pix_y_r;
  logic [EDGE_W-1:0]   area_abs_r;
  logic                sgn_r, degen_r, inside_r;
  edge_t               w0_r, w1_r, w2_r;

  vertex_t             pix_v;
  edge_t               area_c, e0_c, e1_c, e2_c, w0_c, w1_c, w2_c;
  logic                inside_c;
  num_t                num_c, div_quot;
  logic                div_done;

  assign tri_ready = (state == S_IDLE) || (state == S_LOADED);
  // A triangle offered alongside a pixel takes priority, so the pixel is refused.
  assign pix_ready = (state == S_LOADED) && !tri_valid;
  assign out_valid = (state == S_OUT);
  assign busy      = !tri_ready;
  assign out_degen = degen_r;

  always_comb begin
    pix_v    = '{x: pix_x_r, y: pix_y_r, z: '0};
    area_c   = edge_fn(tri_r.p, tri_r.q, tri_r.r);
    e0_c     = edge_fn(tri_r.q, tri_r.r, pix_v);
    e1_c     = edge_fn(tri_r.r, tri_r.p, pix_v);
    e2_c     = edge_fn(tri_r.p, tri_r.q, pix_v);
    // Clockwise triangles are folded onto the counter-clockwise convention.
    w0_c     = sgn_r ? -e0_c : e0_c;
    w1_c     = sgn_r ? -e1_c : e1_c;
    w2_c     = sgn_r ? -e2_c : e2_c;
    inside_c = !w0_c[EDGE_W-1] && !w1_c[EDGE_W-1] && !w2_c[EDGE_W-1];
    num_c    = num_t'(tri_r.p.z) * num_t'(w0_r)
             + num_t'(tri_r.q.z) * num_t'(w1_r)
             + num_t'(tri_r.r.z) * num_t'(w2_r);
  end

  seq_sdiv #(.N_W(NUM_W), .D_W(EDGE_W)) u_div (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (state == S_MUL),
    .dividend (num_c),
    .divisor  (area_abs_r),
    .done     (div_done),
    .quotient (div_quot)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (tri_valid) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_LOADED;
      S_LOADED: begin
        if (tri_valid)      state_nxt = S_SETUP;
        else if (pix_valid) state_nxt = S_EDGE;
      end
      S_EDGE:   state_nxt = degen_r ? S_OUT : S_MUL;
      S_MUL:    state_nxt = S_DIV;
      S_DIV:    if (div_done) state_nxt = S_OUT;
      S_OUT:    if (out_ready) state_nxt = S_LOADED;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Architecturally visible registers: these return to known values on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      degen_r    <= 1'b0;
      out_z      <= '0;
      out_inside <= 1'b0;
    end else begin
      if (state == S_SETUP) degen_r <= (area_c == '0);
      if (state == S_EDGE && degen_r) begin
        out_z      <= '0;
        out_inside <= 1'b0;
      end else if (state == S_DIV && div_done) begin
        out_z      <= sat_to_zw(div_quot);
        out_inside <= inside_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tri_valid && tri_ready) tri_r <= tri_data;
    if (state == S_SETUP) begin
      sgn_r      <= area_c[EDGE_W-1];
      area_abs_r <= area_c[EDGE_W-1] ? -area_c : area_c;
    end
    if (pix_valid && pix_ready) begin
      pix_x_r <= pix_x;
      pix_y_r <= pix_y;
    end
    if (state == S_EDGE) begin
      w0_r     <= w0_c;
      w1_r     <= w1_c;
      w2_r     <= w2_c;
      inside_r <= inside_c;
    end
  end

endmodule

// File: tb/tb_tri_z_interp.sv
// Self-checking bench for tri_z_interp: directed vector table, random triangles
// against an arithmetic plane model, plus stall, priority and reset sequences.
module tb_tri_z_interp;

  localparam int CW        = 16;
  localparam int ZW        = 16;
  localparam int NUM_W     = ZW + (2*CW + 3) + 2;
  localparam int LAT_FULL  = 3 + NUM_W;
  localparam int LAT_DEGEN = 2;
  localparam int WAIT_MAX  = 400;

  logic                       clk = 1'b0;
  logic                       n_rst = 1'b0;
  logic                       tri_valid = 1'b0, pix_valid = 1'b0, out_ready = 1'b1;
  logic                       tri_ready, pix_ready, out_valid, out_inside, out_degen, busy;
  logic [3*(2*CW+ZW)-1:0]     tri_data = '0;
  logic signed [CW-1:0]       pix_x = '0, pix_y = '0;
  logic signed [ZW-1:0]       out_z;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tri_z_interp dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .tri_valid  (tri_valid),
    .tri_ready  (tri_ready),
    .tri_data   (tri_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_z      (out_z),
    .out_inside (out_inside),
    .out_degen  (out_degen),
    .busy       (busy)
  );

  typedef struct {
    int px, py, pz, qx, qy, qz, rx, ry, rz;
  } tri_t;

  typedef struct {
    string name;
    tri_t  t;
    int    x, y;
    int    ez;
    bit    ein, edeg;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Plane model: signed areas straight from coordinates, z = sum(z_i*E_i)/area.
  function automatic longint efn(longint ax, longint ay, longint bx, longint by,
                                 longint cx, longint cy);
    return (bx - ax) * (cy - ay) - (by - ay) * (cx - ax);
  endfunction

  task automatic model(input tri_t t, input int x, input int y,
                       output longint z, output bit ins, output bit deg);
    longint a, e0, e1, e2, num;
    a = efn(t.px, t.py, t.qx, t.qy, t.rx, t.ry);
    if (a == 0) begin
      z = 0; ins = 0; deg = 1;
    end else begin
      e0  = efn(t.qx, t.qy, t.rx, t.ry, x, y);
      e1  = efn(t.rx, t.ry, t.px, t.py, x, y);
      e2  = efn(t.px, t.py, t.qx, t.qy, x, y);
      num = t.pz * e0 + t.qz * e1 + t.rz * e2;
      z   = num / a;
      if (z > 32767)  z = 32767;
      if (z < -32768) z = -32768;
      ins = (a > 0) ? (e0 >= 0 && e1 >= 0 && e2 >= 0) : (e0 <= 0 && e1 <= 0 && e2 <= 0);
      deg = 0;
    end
  endtask

  function automatic logic [3*(2*CW+ZW)-1:0] pack(input tri_t t);
    return {16'(t.px), 16'(t.py), 16'(t.pz), 16'(t.qx), 16'(t.qy), 16'(t.qz),
            16'(t.rx), 16'(t.ry), 16'(t.rz)};
  endfunction

  function automatic tri_t mk_tri(input int px, py, pz, qx, qy, qz, rx, ry, rz);
    tri_t t;
    t = '{px, py, pz, qx, qy, qz, rx, ry, rz};
    return t;
  endfunction

  function automatic vec_t mk(input string n, input tri_t t, input int x, y, ez,
                              input bit ein, edeg);
    vec_t v;
    v.name = n; v.t = t; v.x = x; v.y = y; v.ez = ez; v.ein = ein; v.edeg = edeg;
    return v;
  endfunction

  function automatic int rnd(input int lo, input int hi);
    return lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic send_tri(input tri_t t);
    int n = 0;
    @(negedge clk);
    tri_data  = pack(t);
    tri_valid = 1'b1;
    while (!tri_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) check("tri_accept_timeout", n, 0);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  // Returns at the first negedge after the accepting edge (latency count 1).
  task automatic send_pix(input int x, input int y);
    int n = 0;
    @(negedge clk);
    pix_x     = 16'(x);
    pix_y     = 16'(y);
    pix_valid = 1'b1;
    while (!pix_ready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) check("pix_accept_timeout", n, 0);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < WAIT_MAX) begin @(negedge clk); lat++; end
    if (!out_valid) check("out_valid_timeout", lat, 0);
  endtask

  task automatic run_pix(input string name, input int x, input int y, input longint ez,
                         input bit ein, input bit edeg);
    int lat;
    send_pix(x, y);
    wait_out(lat);
    check({name, "_latency"}, lat, edeg ? LAT_DEGEN : LAT_FULL);
    check({name, "_z"}, out_z, ez);
    check({name, "_inside"}, out_inside, ein);
    check({name, "_degen"}, out_degen, edeg);
    @(negedge clk);
    check({name, "_valid_drop"}, out_valid, 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_tri_ready"}, tri_ready, 1);
    check({name, "_pix_ready"}, pix_ready, 0);
    check({name, "_out_valid"}, out_valid, 0);
    check({name, "_out_z"}, out_z, 0);
    check({name, "_out_inside"}, out_inside, 0);
    check({name, "_out_degen"}, out_degen, 0);
    check({name, "_busy"}, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t   vecs[16];
    tri_t   ta, tcw, tdg, tsat, tneg, ttr, tb, tr;
    longint mz;
    bit     mi, md;
    int     lat, seen;

    ta   = mk_tri(0, 0, 100,  10, 0, 200,  0, 10, 300);
    tcw  = mk_tri(0, 0, 100,  0, 10, 300,  10, 0, 200);
    tdg  = mk_tri(0, 0, 5,    5, 5, 5,     10, 10, 5);
    tsat = mk_tri(0, 0, 0,    1, 0, 32767, 0, 1, 0);
    tneg = mk_tri(0, 0, -100, 10, 0, -200, 0, 10, -300);
    ttr  = mk_tri(0, 0, 0,    3, 0, 10,    0, 3, 0);

    vecs[0]  = mk("ccw_p0",      ta,   0,   0,    100,   1, 0);
    vecs[1]  = mk("ccw_edge",    ta,   5,   0,    150,   1, 0);
    vecs[2]  = mk("ccw_in",      ta,   2,   2,    160,   1, 0);
    vecs[3]  = mk("ccw_out",     ta,   20,  20,   700,   0, 0);
    vecs[4]  = mk("cw_p0",       tcw,  0,   0,    100,   1, 0);
    vecs[5]  = mk("cw_edge",     tcw,  5,   0,    150,   1, 0);
    vecs[6]  = mk("cw_in",       tcw,  2,   2,    160,   1, 0);
    vecs[7]  = mk("cw_out",      tcw,  20,  20,   700,   0, 0);
    vecs[8]  = mk("degen_a",     tdg,  3,   7,    0,     0, 1);
    vecs[9]  = mk("degen_b",     tdg,  5,   5,    0,     0, 1);
    vecs[10] = mk("sat_vertex",  tsat, 1,   0,    32767, 1, 0);
    vecs[11] = mk("sat_hi",      tsat, 10,  0,    32767, 0, 0);
    vecs[12] = mk("sat_lo",      tsat, -10, 0,    -32768, 0, 0);
    vecs[13] = mk("neg_z",       tneg, 3,   3,    -190,  1, 0);
    vecs[14] = mk("trunc_pos",   ttr,  1,   0,    3,     1, 0);
    vecs[15] = mk("trunc_neg",   ttr,  -1,  0,    -3,    0, 0);

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    n_rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      send_tri(vecs[i].t);
      run_pix(vecs[i].name, vecs[i].x, vecs[i].y, vecs[i].ez, vecs[i].ein, vecs[i].edeg);
    end

    for (int i = 0; i < 40; i++) begin
      int span, zs;
      span = (i % 5 == 4) ? 30000 : 300;
      zs   = (i % 3 == 0) ? 30000 : 2000;
      tr = mk_tri(rnd(-span, span), rnd(-span, span), rnd(-zs, zs),
                  rnd(-span, span), rnd(-span, span), rnd(-zs, zs), 0, 0, rnd(-zs, zs));
      if (i % 8 == 7) begin
        tr.rx = 2 * tr.qx - tr.px;
        tr.ry = 2 * tr.qy - tr.py;
        if (tr.rx > 32767 || tr.rx < -32768 || tr.ry > 32767 || tr.ry < -32768) begin
          tr.rx = tr.qx; tr.ry = tr.qy;
        end
      end else begin
        tr.rx = rnd(-span, span);
        tr.ry = rnd(-span, span);
      end
      send_tri(tr);
      for (int k = 0; k < 2; k++) begin
        int x, y;
        x = rnd(-span, span);
        y = rnd(-span, span);
        model(tr, x, y, mz, mi, md);
        run_pix($sformatf("rand%0d_%0d", i, k), x, y, mz, mi, md);
      end
    end

    // Downstream stall: result must hold and no new pixel may be taken.
    send_tri(ta);
    out_ready = 1'b0;
    send_pix(2, 2);
    wait_out(lat);
    check("stall_latency", lat, LAT_FULL);
    for (int k = 0; k < 10; k++) begin
      check("stall_valid", out_valid, 1);
      check("stall_z", out_z, 160);
      check("stall_inside", out_inside, 1);
      check("stall_pix_ready", pix_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", out_valid, 0);
    check("loaded_pix_ready", pix_ready, 1);

    // Triangle and pixel offered together in LOADED: triangle wins.
    tb = mk_tri(0, 0, 1000, 10, 0, 1000, 0, 10, 1000);
    tri_data  = pack(tb);
    tri_valid = 1'b1;
    pix_x     = 16'(5);
    pix_y     = 16'(0);
    pix_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
    pix_valid = 1'b0;
    check("tri_wins_setup_busy", busy, 1);
    @(negedge clk);
    check("tri_wins_back_loaded", busy, 0);
    check("tri_wins_no_output", out_valid, 0);
    run_pix("tri_wins_newtri", 5, 0, 1000, 1, 0);

    // Asynchronous reset in the middle of a divide.
    send_tri(ta);
    send_pix(20, 20);
    repeat (20) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 n_rst = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("post_reset_stray_valid", seen, 0);
    check_reset_vals("post_reset_idle");

    send_tri(ta);
    run_pix("recover", 5, 0, 150, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
